// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Everything the load formatter needs once the request has been launched
    typedef struct packed {
        logic [2:0] fun3;
        logic [1:0] off;
    } ld_fmt_t;

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed lane of a raw memory word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  fun3,
    input  logic [1:0]  offset,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane extraction, then extension chosen by access type
    always_comb begin
        lane_b = raw[8*offset +: 8];
        lane_h = offset[1] ? raw[31:16] : raw[15:0];
        case (fun3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'd0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'd0, lane_h};
            F3_W:    result = raw;
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I MEM-stage load/store unit driving a req/ack data-memory port.
// Latency: 2+k cycles in MEM (k = memory wait cycles), abort after MAX_WAIT REQ cycles.
// Backpressure: stall holds the pipeline while an access is launching or outstanding.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  fun3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    lsu_state_t  state;
    logic [7:0]  wait_cnt;
    ld_fmt_t     fmt_q;
    logic [31:0] rdata_q;
    logic        to_err_q;

    logic        one_op;
    logic        both_op;
    logic        legal;
    logic        aligned;
    logic        go;
    logic        timeout;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] ld_result;

    // Decode legality and alignment of the op currently presented in MEM
    always_comb begin
        legal = 1'b0;
        if (load) begin
            case (fun3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: legal = 1'b1;
                default:                        legal = 1'b0;
            endcase
        end else begin
            case (fun3)
                F3_B, F3_H, F3_W: legal = 1'b1;
                default:          legal = 1'b0;
            endcase
        end
        case (fun3[1:0])
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated store data for the launch
    always_comb begin
        case (fun3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata;
            end
        endcase
    end

    assign one_op  = load ^ store;
    assign both_op = load & store;
    assign go      = (state == IDLE) & one_op & legal & aligned;
    assign timeout = (state == REQ) & ~mem_ack & (wait_cnt == LAST_WAIT);

    // Rejected ops never stall; timeout error is reported in the DONE cycle
    assign stall    = ~rst & (go | (state == REQ));
    assign misalign = ~rst & (state == IDLE) & one_op & legal & ~aligned;
    assign err      = ~rst & (((state == IDLE) & (both_op | (one_op & ~legal)))
                              | ((state == DONE) & to_err_q));
    assign rdata    = (state == DONE) ? rdata_q : 32'd0;

    lsu_load_align u_load_align (
        .fun3   (fmt_q.fun3),
        .offset (fmt_q.off),
        .raw    (mem_rdata),
        .result (ld_result)
    );

    // IDLE -> REQ -> DONE sequencing with registered memory port
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            fmt_q     <= '0;
            rdata_q   <= 32'd0;
            to_err_q  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state     <= REQ;
                        wait_cnt  <= 8'd0;
                        to_err_q  <= 1'b0;
                        fmt_q     <= '{fun3: fun3, off: addr[1:0]};
                        mem_req   <= 1'b1;
                        mem_we    <= store;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_be    <= be_next;
                        mem_wdata <= wdata_next;
                    end
                end
                REQ: begin
                    if (mem_ack || timeout) begin
                        state    <= DONE;
                        wait_cnt <= 8'd0;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_be   <= 4'd0;
                        rdata_q  <= (mem_ack && !mem_we) ? ld_result : 32'd0;
                        to_err_q <= ~mem_ack;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    rdata_q  <= 32'd0;
                    to_err_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
